// File: rtl/toast_mem_arbiter.sv
// Single-port memory bus arbiter shared by the Toast RV32i fetch and MEM stages.
// One outstanding transaction, data priority with bounded fetch starvation, fetch flush kill.
module toast_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_stall_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [DATA_WIDTH/8-1:0] dm_be_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
  output logic                    dm_rvalid_o,
  output logic [DATA_WIDTH-1:0]   dm_rdata_o,
  output logic                    dm_stall_o,
  input  logic                    flush_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    REQ_I,
    REQ_D,
    WAIT_I,
    WAIT_D
  } state_e;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  kill_q, kill_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;

  logic resp_i, resp_d, arb_en, pick_i, pick_d;

  assign resp_i = (state_q == WAIT_I) && mem_rvalid_i;
  assign resp_d = (state_q == WAIT_D) && mem_rvalid_i;
  assign arb_en = (state_q == IDLE) || resp_i || resp_d;
  // Data wins unless fetch has waited through STARVE_LIMIT data grants.
  assign pick_d = dm_req_i && !((starve_cnt_q == STARVE_MAX) && if_req_i);
  assign pick_i = if_req_i && !pick_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      kill_q       <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      kill_q       <= kill_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      REQ_I: if (mem_gnt_i) begin
        state_d   = WAIT_I;
        mem_req_d = 1'b0;
      end
      REQ_D: if (mem_gnt_i) begin
        state_d   = WAIT_D;
        mem_req_d = 1'b0;
      end
      default: ;
    endcase

    if (arb_en) begin
      if (pick_d) begin
        state_d     = REQ_D;
        mem_req_d   = 1'b1;
        mem_we_d    = dm_we_i;
        mem_be_d    = dm_be_i;
        mem_addr_d  = dm_addr_i;
        mem_wdata_d = dm_wdata_i;
      end else if (pick_i) begin
        state_d     = REQ_I;
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b0;
        mem_be_d    = '1;
        mem_addr_d  = if_addr_i;
        mem_wdata_d = '0;
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    end
  end

  // A killed fetch still has to drain its bus response before the flag drops.
  always_comb begin
    kill_d = kill_q;
    if (resp_i) begin
      kill_d = 1'b0;
    end else if (flush_i && ((state_q == REQ_I) || (state_q == WAIT_I))) begin
      kill_d = 1'b1;
    end
    if (arb_en && pick_i && flush_i) begin
      kill_d = 1'b1;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i || (arb_en && pick_i)) begin
      starve_cnt_d = '0;
    end else if (arb_en && pick_d && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  assign if_rvalid_o = resp_i && !kill_q && !flush_i && !reset_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign if_stall_o  = (if_req_i && !if_rvalid_o) || kill_q;

  assign dm_rvalid_o = resp_d && !reset_i;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
  assign dm_stall_o  = dm_req_i && !dm_rvalid_o;

endmodule

// File: tb/tb_toast_mem_arbiter.sv
// Directed bench for toast_mem_arbiter: per-cycle vector table plus a starvation
// ordering sequence. Inputs change at the falling edge, outputs are sampled 1ns later.
module tb_toast_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_stall_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        dm_stall_o;
  logic        flush_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  toast_mem_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(2)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .if_stall_o  (if_stall_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_be_i     (dm_be_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rvalid_o (dm_rvalid_o),
    .dm_rdata_o  (dm_rdata_o),
    .dm_stall_o  (dm_stall_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  typedef struct {
    string       name;
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        dmr, we;
    logic [3:0]  be;
    logic [31:0] dma, wd;
    logic        fl, gnt, rv;
    logic [31:0] rd;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    logic        e_irv;
    logic [31:0] e_ird;
    logic        e_ist, e_drv;
    logic [31:0] e_drd;
    logic        e_dst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    string nm, logic rst, logic ifr, logic [31:0] ifa, logic dmr, logic we, logic [3:0] be,
    logic [31:0] dma, logic [31:0] wd, logic fl, logic gnt, logic rv, logic [31:0] rd,
    logic e_req, logic e_we, logic [3:0] e_be, logic [31:0] e_addr, logic [31:0] e_wd,
    logic e_irv, logic [31:0] e_ird, logic e_ist, logic e_drv, logic [31:0] e_drd, logic e_dst);
    vec_t v;
    v.name = nm; v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.we = we; v.be = be;
    v.dma = dma; v.wd = wd; v.fl = fl; v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_we = e_we; v.e_be = e_be; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_irv = e_irv; v.e_ird = e_ird; v.e_ist = e_ist; v.e_drv = e_drv; v.e_drd = e_drd;
    v.e_dst = e_dst;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk_i);
    reset_i      = v.rst;
    if_req_i     = v.ifr;
    if_addr_i    = v.ifa;
    dm_req_i     = v.dmr;
    dm_we_i      = v.we;
    dm_be_i      = v.be;
    dm_addr_i    = v.dma;
    dm_wdata_i   = v.wd;
    flush_i      = v.fl;
    mem_gnt_i    = v.gnt;
    mem_rvalid_i = v.rv;
    mem_rdata_i  = v.rd;
    #1;
    checkOutput({v.name, ".mem_req"},   32'(mem_req_o),   32'(v.e_req));
    checkOutput({v.name, ".mem_we"},    32'(mem_we_o),    32'(v.e_we));
    checkOutput({v.name, ".mem_be"},    32'(mem_be_o),    32'(v.e_be));
    checkOutput({v.name, ".mem_addr"},  mem_addr_o,       v.e_addr);
    checkOutput({v.name, ".mem_wdata"}, mem_wdata_o,      v.e_wd);
    checkOutput({v.name, ".if_rvalid"}, 32'(if_rvalid_o), 32'(v.e_irv));
    checkOutput({v.name, ".if_rdata"},  if_rdata_o,       v.e_ird);
    checkOutput({v.name, ".if_stall"},  32'(if_stall_o),  32'(v.e_ist));
    checkOutput({v.name, ".dm_rvalid"}, 32'(dm_rvalid_o), 32'(v.e_drv));
    checkOutput({v.name, ".dm_rdata"},  dm_rdata_o,       v.e_drd);
    checkOutput({v.name, ".dm_stall"},  32'(dm_stall_o),  32'(v.e_dst));
  endtask

  initial begin
    string order;
    string exp_order;
    int    n;
    bit    pend;

    reset_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0; flush_i = 1'b0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);

    // Columns: rst ifr ifa dmr we be dma wd fl gnt rv rd | req we be addr wdata irv ird ist drv drd dst
    vecs.push_back(mk("rst0", 1,0,32'h0,   0,0,4'h0,32'h0,0,0,0,0,32'h0,  0,0,4'h0,32'h0,32'h0,0,32'h0,0,0,32'h0,0));
    vecs.push_back(mk("rst1", 1,1,32'h200, 0,0,4'h0,32'h0,0,0,0,0,32'h0,  0,0,4'h0,32'h0,32'h0,0,32'h0,1,0,32'h0,0));
    // Single load, immediate grant.
    vecs.push_back(mk("ld_t0",0,0,32'h0,   1,0,4'hF,32'h100,32'h0,0,0,0,32'h0,  0,0,4'h0,32'h0,32'h0,0,32'h0,0,0,32'h0,1));
    vecs.push_back(mk("ld_t1",0,0,32'h0,   1,0,4'hF,32'h100,32'h0,0,1,0,32'h0,  1,0,4'hF,32'h100,32'h0,0,32'h0,0,0,32'h0,1));
    vecs.push_back(mk("ld_t2",0,0,32'h0,   0,0,4'hF,32'h100,32'h0,0,0,1,32'hDEADBEEF, 0,0,4'hF,32'h100,32'h0,0,32'h0,0,1,32'hDEADBEEF,0));
    vecs.push_back(mk("stray",0,0,32'h0,   0,0,4'hF,32'h100,32'h0,0,0,1,32'h55, 0,0,4'hF,32'h100,32'h0,0,32'h0,0,0,32'h0,0));
    // Store and fetch arrive together: store first, then fetch.
    vecs.push_back(mk("sf_0", 0,1,32'h200, 1,1,4'h3,32'h140,32'h1234,0,0,0,32'h0, 0,0,4'hF,32'h100,32'h0,0,32'h0,1,0,32'h0,1));
    vecs.push_back(mk("sf_1", 0,1,32'h200, 1,1,4'h3,32'h140,32'h1234,0,1,0,32'h0, 1,1,4'h3,32'h140,32'h1234,0,32'h0,1,0,32'h0,1));
    vecs.push_back(mk("sf_2", 0,1,32'h200, 0,1,4'h3,32'h140,32'h1234,0,0,1,32'h0, 0,1,4'h3,32'h140,32'h1234,0,32'h0,1,1,32'h0,0));
    vecs.push_back(mk("sf_3", 0,1,32'h200, 0,0,4'h0,32'h0,32'h0,0,1,0,32'h0,      1,0,4'hF,32'h200,32'h0,0,32'h0,1,0,32'h0,0));
    vecs.push_back(mk("sf_4", 0,0,32'h200, 0,0,4'h0,32'h0,32'h0,0,0,1,32'h13,     0,0,4'hF,32'h200,32'h0,1,32'h13,0,0,32'h0,0));
    // Flush during WAIT_I: response swallowed, next fetch normal.
    vecs.push_back(mk("fl_0", 0,1,32'h300, 0,0,4'h0,32'h0,32'h0,0,0,0,32'h0,      0,0,4'hF,32'h200,32'h0,0,32'h0,1,0,32'h0,0));
    vecs.push_back(mk("fl_1", 0,1,32'h300, 0,0,4'h0,32'h0,32'h0,0,1,0,32'h0,      1,0,4'hF,32'h300,32'h0,0,32'h0,1,0,32'h0,0));
    vecs.push_back(mk("fl_2", 0,1,32'h300, 0,0,4'h0,32'h0,32'h0,1,0,0,32'h0,      0,0,4'hF,32'h300,32'h0,0,32'h0,1,0,32'h0,0));
    vecs.push_back(mk("fl_3", 0,0,32'h300, 0,0,4'h0,32'h0,32'h0,0,0,0,32'h0,      0,0,4'hF,32'h300,32'h0,0,32'h0,1,0,32'h0,0));
    vecs.push_back(mk("fl_4", 0,0,32'h300, 0,0,4'h0,32'h0,32'h0,0,0,1,32'hAAAA,   0,0,4'hF,32'h300,32'h0,0,32'h0,1,0,32'h0,0));
    vecs.push_back(mk("fl_5", 0,1,32'h304, 0,0,4'h0,32'h0,32'h0,0,0,0,32'h0,      0,0,4'hF,32'h300,32'h0,0,32'h0,1,0,32'h0,0));
    vecs.push_back(mk("fl_6", 0,1,32'h304, 0,0,4'h0,32'h0,32'h0,0,1,0,32'h0,      1,0,4'hF,32'h304,32'h0,0,32'h0,1,0,32'h0,0));
    vecs.push_back(mk("fl_7", 0,0,32'h304, 0,0,4'h0,32'h0,32'h0,0,0,1,32'h5555,   0,0,4'hF,32'h304,32'h0,1,32'h5555,0,0,32'h0,0));
    // Flush coinciding with the fetch response.
    vecs.push_back(mk("fr_0", 0,1,32'h308, 0,0,4'h0,32'h0,32'h0,0,0,0,32'h0,      0,0,4'hF,32'h304,32'h0,0,32'h0,1,0,32'h0,0));
    vecs.push_back(mk("fr_1", 0,1,32'h308, 0,0,4'h0,32'h0,32'h0,0,1,0,32'h0,      1,0,4'hF,32'h308,32'h0,0,32'h0,1,0,32'h0,0));
    vecs.push_back(mk("fr_2", 0,0,32'h308, 0,0,4'h0,32'h0,32'h0,1,0,1,32'h66,     0,0,4'hF,32'h308,32'h0,0,32'h0,0,0,32'h0,0));
    vecs.push_back(mk("fr_3", 0,0,32'h308, 0,0,4'h0,32'h0,32'h0,0,0,0,32'h0,      0,0,4'hF,32'h308,32'h0,0,32'h0,0,0,32'h0,0));
    // Grant withheld five cycles in REQ_D.
    vecs.push_back(mk("gw_0", 0,0,32'h0, 1,1,4'hC,32'h180,32'hCAFEF00D,0,0,0,32'h0, 0,0,4'hF,32'h308,32'h0,0,32'h0,0,0,32'h0,1));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk($sformatf("gw_%0d", i), 0,0,32'h0, 1,1,4'hC,32'h180,32'hCAFEF00D,0,0,0,32'h0,
                        1,1,4'hC,32'h180,32'hCAFEF00D,0,32'h0,0,0,32'h0,1));
    vecs.push_back(mk("gw_6", 0,0,32'h0, 1,1,4'hC,32'h180,32'hCAFEF00D,0,1,0,32'h0, 1,1,4'hC,32'h180,32'hCAFEF00D,0,32'h0,0,0,32'h0,1));
    vecs.push_back(mk("gw_7", 0,0,32'h0, 0,1,4'hC,32'h180,32'hCAFEF00D,0,0,1,32'h12345678, 0,1,4'hC,32'h180,32'hCAFEF00D,0,32'h0,0,1,32'h12345678,0));
    // Reset in WAIT_D, stray response afterwards.
    vecs.push_back(mk("rw_0", 0,0,32'h0, 1,0,4'hF,32'h1C0,32'h0,0,0,0,32'h0, 0,1,4'hC,32'h180,32'hCAFEF00D,0,32'h0,0,0,32'h0,1));
    vecs.push_back(mk("rw_1", 0,0,32'h0, 1,0,4'hF,32'h1C0,32'h0,0,1,0,32'h0, 1,0,4'hF,32'h1C0,32'h0,0,32'h0,0,0,32'h0,1));
    vecs.push_back(mk("rw_2", 1,0,32'h0, 1,0,4'hF,32'h1C0,32'h0,0,0,0,32'h0, 0,0,4'hF,32'h1C0,32'h0,0,32'h0,0,0,32'h0,1));
    vecs.push_back(mk("rw_3", 0,0,32'h0, 0,0,4'h0,32'h0,32'h0,0,0,0,32'h0,   0,0,4'h0,32'h0,32'h0,0,32'h0,0,0,32'h0,0));
    vecs.push_back(mk("rw_4", 0,0,32'h0, 0,0,4'h0,32'h0,32'h0,0,0,1,32'hBAD, 0,0,4'h0,32'h0,32'h0,0,32'h0,0,0,32'h0,0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Starvation: both requesters held, bus grants at once and answers next cycle.
    order = "";
    exp_order = "DDIDDI";
    n = 0;
    pend = 1'b0;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = '0;
    if_req_i = 1'b1; if_addr_i = 32'h400;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h500; dm_wdata_i = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk_i);
      if (pend) begin
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1;
        pend = 1'b0;
        if (n == 6) begin
          if_req_i = 1'b0;
          dm_req_i = 1'b0;
        end
      end else if (n == 6) begin
        mem_rvalid_i = 1'b0;
        break;
      end else if (mem_req_o) begin
        order = {order, (mem_addr_o == 32'h500) ? "D" : "I"};
        n++;
        mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b0;
        pend = 1'b1;
      end else begin
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
      end
    end
    checkOutput("starve_grant_count", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("starve_grant%0d", i),
                  (order.len() > i) ? 32'(order[i]) : 32'h0, 32'(exp_order[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
